// File: rtl/ctrlport_mu_sequencer.sv
// ctrlport_mu_sequencer
//
// CtrlPort initiator that steps the adaptive filter's mu register through a
// small table. Each step writes one table entry to REG_ADDR, optionally reads
// it back and compares, then waits dwell_cycles before the next step.
//
// Ports
//   ap_clk, ap_rst_n          clock, async active-low reset
//   start, abort              one-cycle control pulses
//   loop_en, verify_en        wrap-around enable, readback enable
//   dwell_cycles              idle cycles between steps
//   cfg_wr_en/idx/mu          table write port (usable in any state)
//   m_ctrlport_req_*          request side (wr/rd pulses, address, data)
//   m_ctrlport_resp_ack/data  response side
//   busy, done                status: not idle / sequence completed pulse
//   err_timeout/err_mismatch  sticky errors, cleared by an accepted start
//   cur_idx                   table entry currently being applied
module ctrlport_mu_sequencer #(
  parameter int          NUM_STEPS = 4,
  parameter logic [19:0] REG_ADDR  = 20'h00000,
  parameter int          TIMEOUT   = 64,
  parameter int          DWELL_W   = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop_en,
  input  logic                         verify_en,
  input  logic [DWELL_W-1:0]           dwell_cycles,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_wr_idx,
  input  logic [31:0]                  cfg_wr_mu,
  output logic                         m_ctrlport_req_wr,
  output logic                         m_ctrlport_req_rd,
  output logic [19:0]                  m_ctrlport_req_addr,
  output logic [31:0]                  m_ctrlport_req_data,
  input  logic                         m_ctrlport_resp_ack,
  input  logic [31:0]                  m_ctrlport_resp_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  output logic                         err_mismatch,
  output logic [$clog2(NUM_STEPS)-1:0] cur_idx
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_WACK  = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RACK  = 3'd4;
  localparam logic [2:0] S_DWELL = 3'd5;

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               abort_q;
  logic [31:0]        mu_tab [NUM_STEPS];

  // The table has no reset; it is only meaningful once software fills it.
  always_ff @(posedge ap_clk) begin
    if (cfg_wr_en) begin
      mu_tab[cfg_wr_idx] <= cfg_wr_mu;
    end
  end

  // NUM_STEPS is a power of two, so the natural wrap gives modulo indexing.
  assign idx_next = idx + IDX_ONE;

  // req_data is captured on the edge that enters WR, so a later table write
  // to the same entry cannot disturb the request already in flight. The
  // captured value is also the reference for the readback compare.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state               <= S_IDLE;
      idx                 <= '0;
      wait_cnt            <= '0;
      dwell_cnt           <= '0;
      abort_q             <= 1'b0;
      m_ctrlport_req_data <= '0;
      done                <= 1'b0;
      err_timeout         <= 1'b0;
      err_mismatch        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        abort_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (abort || abort_q) begin
            abort_q <= 1'b0;
          end else if (start) begin
            err_timeout         <= 1'b0;
            err_mismatch        <= 1'b0;
            idx                 <= '0;
            m_ctrlport_req_data <= mu_tab[0];
            state               <= S_WR;
          end
        end
        S_WR: begin
          wait_cnt <= CNT_ONE;
          state    <= S_WACK;
        end
        S_WACK: begin
          if (m_ctrlport_resp_ack) begin
            dwell_cnt <= dwell_cycles;
            state     <= verify_en ? S_RD : S_DWELL;
          end else if (wait_cnt == TIMEOUT_C) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        S_RD: begin
          wait_cnt <= CNT_ONE;
          state    <= S_RACK;
        end
        S_RACK: begin
          if (m_ctrlport_resp_ack) begin
            if (m_ctrlport_resp_data != m_ctrlport_req_data) begin
              err_mismatch <= 1'b1;
              state        <= S_IDLE;
            end else begin
              dwell_cnt <= dwell_cycles;
              state     <= S_DWELL;
            end
          end else if (wait_cnt == TIMEOUT_C) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        S_DWELL: begin
          // DWELL is the only mid-sequence point where no request is pending,
          // so a latched abort is honoured here and nowhere else.
          if (abort || abort_q) begin
            abort_q <= 1'b0;
            state   <= S_IDLE;
          end else if (dwell_cnt == '0) begin
            if (idx == LAST_IDX && !loop_en) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              idx                 <= idx_next;
              m_ctrlport_req_data <= mu_tab[idx_next];
              state               <= S_WR;
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Request strobes and address decode straight from the state so they are
  // single-cycle by construction and can never overlap.
  assign m_ctrlport_req_wr   = (state == S_WR);
  assign m_ctrlport_req_rd   = (state == S_RD);
  assign m_ctrlport_req_addr = (state == S_WR || state == S_WACK ||
                                state == S_RD || state == S_RACK) ? REG_ADDR : 20'h00000;
  assign busy                = (state != S_IDLE);
  assign cur_idx             = idx;

endmodule

// File: doc/ctrlport_mu_sequencer.md
Name: ctrlport_mu_sequencer

Overview:
CtrlPort initiator that drives the adaptive filter's step-size register from the requesting side. It holds a small table of step-size (mu) values and writes them in order to one register address. After each write it can read the register back and check the value, then waits a programmable dwell time before the next step. Used in test harnesses and for on-chip mu annealing, wired to the same CtrlPort request/response signals the filter block answers on.

Parameters:
NUM_STEPS, 4, table depth in entries; must be a power of two, at least 2
REG_ADDR, 20'h00000, CtrlPort address of the mu register
TIMEOUT, 64, cycles to wait for resp_ack before declaring an error
DWELL_W, 16, width of the dwell counter

Ports:
ap_clk  in  1  single clock for all logic
ap_rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a sequence when idle
abort  in  1  one-cycle pulse; stops the sequence at the next safe point
loop_en  in  1  1 = wrap to entry 0 after the last entry instead of finishing
verify_en  in  1  1 = read back and compare after every write
dwell_cycles  in  DWELL_W  idle cycles between steps
cfg_wr_en  in  1  table write strobe
cfg_wr_idx  in  log2(NUM_STEPS)  table entry index
cfg_wr_mu  in  32  table entry value (Q1.31-style mu)
m_ctrlport_req_wr  out  1  write request pulse
m_ctrlport_req_rd  out  1  read request pulse
m_ctrlport_req_addr  out  20  request address
m_ctrlport_req_data  out  32  write data
m_ctrlport_resp_ack  in  1  response strobe
m_ctrlport_resp_data  in  32  read data
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a non-looping sequence completes
err_timeout  out  1  sticky; cleared by start
err_mismatch  out  1  sticky; cleared by start
cur_idx  out  log2(NUM_STEPS)  index of the entry currently being applied

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0, state IDLE, counters 0.
  - The table does not reset. Its contents are undefined until written.
- Table write:
  - cfg_wr_en writes the table in any state.
  - A write to the entry currently in flight does not change m_ctrlport_req_data. The new value applies on that entry's next use.
- States:
  - IDLE: on start, clear both err flags, set idx=0, go to WR.
  - WR:
    - Assert req_wr for exactly 1 cycle.
    - req_addr=REG_ADDR; req_data=table[idx].
    - Go to WACK.
  - WACK:
    - Count cycles starting at 1.
    - On resp_ack: if verify_en go to RD, else go to DWELL.
    - If the count reaches TIMEOUT with no ack: set err_timeout, go to IDLE.
  - RD:
    - Assert req_rd for 1 cycle at REG_ADDR.
    - Go to RACK.
  - RACK:
    - Same timeout rule as WACK.
    - On resp_ack, compare resp_data with the value that was written. If they differ, set err_mismatch and go to IDLE.
    - Otherwise go to DWELL.
  - DWELL:
    - Load the counter with dwell_cycles and count down; dwell_cycles=0 means leave on the next cycle.
    - At 0:
      - If idx==NUM_STEPS-1 and loop_en=0: pulse done, go to IDLE.
      - Otherwise idx = idx+1 modulo NUM_STEPS, go to WR.
- req_addr and req_data hold their value from WR through the end of WACK. Outside WR and RD they are don't-care.
- Latency:
  - start to req_wr: 1 cycle.
  - Ack to the next req_wr, verify off: dwell_cycles+2 cycles.
- Never more than one outstanding request; req_wr and req_rd are never high in the same cycle.
- An ack that arrives while in IDLE, WR, RD or DWELL is ignored.
- Abort:
  - Aborts are latched.
  - A latched abort takes effect only in DWELL or IDLE, so a request that is in flight always finishes or times out first.
  - On taking effect: go to IDLE with no done pulse, and clear the latch.
  - abort arriving in the same cycle as start while IDLE: abort wins, stay IDLE.
- start while busy is ignored.
- cur_idx follows idx; it is 0 in IDLE after reset and otherwise keeps its last value.
- Asserting reset mid-transaction drops the request immediately; the slave's ack after reset is ignored.

Test Plan:
- Table {0x199A0000, 0x0CCD0000, 0x06660000, 0x03330000}, verify off, dwell 3, ack returned 1 cycle after each request, start → four req_wr pulses carrying those values in order at REG_ADDR; done pulses once; busy then falls.
- verify on, slave echoes the written value → each req_wr is followed by one req_rd; err_mismatch stays 0.
- verify on, slave returns 0xDEADBEEF on the entry-1 readback → err_mismatch=1 and return to IDLE; no third write; no done pulse.
- Slave never acks → err_timeout=1 exactly TIMEOUT cycles after the first WACK cycle; busy=0; the next start clears err_timeout.
- loop_en=1 → writes wrap 3→0 continuously; abort during a WACK lets the ack complete, then the block goes IDLE with no further req_wr.
- Reset pulse in the middle of RACK → all outputs 0 immediately; a late resp_ack produces no state change.
